operand_loader_4: RTL
=====================

// Module: operand_loader_4
// PURPOSE
//   Write side of the 4-way operand bank. Debounces push-buttons, keeps a 2-bit
//   select, and loads a switch value into one of four WIDTH-bit registers A/B/C/D.
//   The bank's registered A..D outputs and SEL feed the 4:1 result/operand mux;
//   SEL replaces that mux's edge-clocked toggle bits with a fully synchronous select.
// PARAMETERS
//   WIDTH           10      data width of DIN and A..D
//   DEBOUNCE_CYCLES 500000  consecutive cycles a raw input must differ from its
//                           debounced level before it is accepted (10 ms @ 50 MHz)
//   CNT_W           19      debounce counter width; 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//   CLK       in   1      single system clock, rising edge
//   RESET_N   in   1      asynchronous, active-low reset
//   BTN       in   2      raw active-high select buttons; BTN[i] press toggles SEL[i]
//   LOAD      in   1      raw active-high load button
//   DIN       in   WIDTH  value to load (switches), sampled on load edge
//   SEL       out  2      current bank select, 00->A 01->B 10->C 11->D
//   A,B,C,D   out  WIDTH  operand registers
//   WR_PULSE  out  1      one-cycle pulse: a register was written on the previous edge
// BEHAVIOUR
//   Reset (RESET_N=0, async): SEL=00, A=B=C=D=0, WR_PULSE=0, all sync flops,
//     debounced levels, counters and press pulses = 0. Held inputs are ignored
//     while in reset.
//   Per raw input (BTN[0], BTN[1], LOAD), identical channel:
//     - 2-FF synchronizer -> s.
//     - If s == stable: cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1: stable <= s,
//       cnt <= 0. Else cnt <= cnt+1. A glitch shorter than DEBOUNCE_CYCLES resets
//       cnt and is never accepted.
//     - press <= stable & ~stable_d (registered, exactly 1 cycle per accepted
//       rising level). Falling edges generate nothing.
//   Latency: a raw 0->1 stable before edge 1 is in s at edge 2, is accepted at
//     edge 2+DEBOUNCE_CYCLES, press is high after edge 3+DEBOUNCE_CYCLES, and
//     SEL/A..D update at edge 4+DEBOUNCE_CYCLES.
//   Select: SEL[i] <= ~SEL[i] on the edge where press_btn[i]=1. Both presses in
//     the same cycle toggle both bits together (00->11). SEL wraps freely.
//   Load: on the edge where press_load=1, the register indexed by the pre-edge
//     SEL gets DIN; others hold; WR_PULSE <= 1 (0 on every other edge).
//   Simultaneous load + select in the same cycle: write uses the OLD SEL; SEL
//     toggles on the same edge.
//   DIN is not synchronized; it is sampled only on the load edge and must be
//     static (switches).
//   Reset mid-debounce or mid-pulse: all progress is discarded. An input still
//     high after reset release is debounced again and then counts as a new press.
//   Held button: exactly one press per accepted rising level, with no auto-repeat.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1 RESET_N=0 with BTN=11, LOAD=1 for 10 cycles -> SEL=00, A..D=0, WR_PULSE=0 throughout
//   2 after reset BTN[0] high 20 cycles then low -> SEL=01 exactly at edge 8; no further change
//   3 BTN[1] high 3 cycles then low, repeated 5x -> SEL stays 00, WR_PULSE never asserts
//   4 SEL=10, DIN=10'h2A5, LOAD pressed -> C=10'h2A5, WR_PULSE high 1 cycle, A/B/D unchanged
//   5 SEL=00, DIN=10'h155, BTN[0] and LOAD rise same cycle -> A=10'h155 and SEL=01 on same edge
//   6 BTN[0] high, RESET_N pulsed low at cycle 4, BTN[0] low before release -> SEL stays 00

Source files
------------

// File: rtl/operand_loader_4.sv
// -----------------------------------------------------------------------------
// operand_loader_4
//   Write side of a 4-way operand bank. Three raw push-button inputs (two select
//   buttons and one load button) are each synchronised, debounced and turned into
//   a single-cycle press pulse. The select presses toggle the bits of a 2-bit
//   bank select. A load press writes the switch value din_i into the register
//   chosen by the select value that was current before the edge.
//
// Ports
//   clk_i       in   1      system clock, rising edge
//   rst_ni      in   1      asynchronous active-low reset
//   btn_i       in   2      raw active-high select buttons, btn_i[i] toggles sel_o[i]
//   load_i      in   1      raw active-high load button
//   din_i       in   WIDTH  value to load (static switches, not synchronised)
//   sel_o       out  2      bank select, 00->A 01->B 10->C 11->D
//   a_o..d_o    out  WIDTH  operand registers
//   wr_pulse_o  out  1      high for one cycle after a register was written
// -----------------------------------------------------------------------------
module operand_loader_4 #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       btn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [1:0]       sel_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] d_o,
  output logic             wr_pulse_o
);

  localparam int               NCH     = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: [0]=btn_i[0], [1]=btn_i[1], [2]=load_i
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] press;

  assign raw_in = {load_i, btn_i};

  // ---------------------------------------------------------------------------
  // Identical synchroniser + debouncer + rising-edge pulse per raw input
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        stable_q     <= 1'b0;
        stable_dly_q <= 1'b0;
        press_q      <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q <= raw_in[gi];
        sync2_q <= sync1_q;
        // Any sample matching the accepted level restarts the count, so only an
        // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
        if (sync2_q == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        stable_dly_q <= stable_q;
        press_q      <= stable_q & ~stable_dly_q;
      end
    end

    assign press[gi] = press_q;
  end

  logic press_load;
  assign press_load = press[2];

  // ---------------------------------------------------------------------------
  // Select, bank registers and write pulse
  // ---------------------------------------------------------------------------
  logic [1:0]       sel_q;
  logic [1:0]       sel_d;
  logic             wr_pulse_q;
  logic             wr_pulse_d;
  logic [WIDTH-1:0] bank_q [4];
  logic [WIDTH-1:0] bank_d [4];

  // Both select bits may toggle on the same edge (00 -> 11).
  assign sel_d      = sel_q ^ press[1:0];
  assign wr_pulse_d = press_load;

  // The write decode uses sel_q (pre-edge select), so a load and a select press
  // in the same cycle write the old bank while the select moves on.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    assign bank_d[gi] = (press_load && (sel_q == 2'(gi))) ? din_i : bank_q[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q      <= 2'b00;
      wr_pulse_q <= 1'b0;
      bank_q     <= '{default: '0};
    end else begin
      sel_q      <= sel_d;
      wr_pulse_q <= wr_pulse_d;
      bank_q     <= bank_d;
    end
  end

  assign sel_o      = sel_q;
  assign wr_pulse_o = wr_pulse_q;
  assign a_o        = bank_q[0];
  assign b_o        = bank_q[1];
  assign c_o        = bank_q[2];
  assign d_o        = bank_q[3];

endmodule
